mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline.
- Arbitrates requests and holds the granted request stable on the memory port until the memory acknowledges.
- Returns the response to the winning requester and raises per-stage stall signals so the pipeline freezes while a stage waits.
- Bounds data-side priority with a streak counter so fetch never starves.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DSTREAK, 4, max consecutive MEM grants while a fetch is pending; range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ready or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch/redirect; cancels the pending or in-flight fetch
- if_ready  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- if_stall  out  1  if_req & ~if_ready
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  data access complete (one-cycle pulse)
- dm_rdata  out  DATA_W  load data
- dm_stall  out  1  dm_req & ~dm_ready
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ack  in  1  memory completion; any latency of 1 or more cycles
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- States: IDLE, GNT_IF, GNT_DM. Reset state is IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dstreak=0, drop=0. if_ready and dm_ready are therefore 0 in reset.
- IDLE arbitration (at the clock edge):
  - Only dm_req → GNT_DM.
  - Only if_req, and if_flush=0 → GNT_IF.
  - Both requests: GNT_IF if dstreak==MAX_DSTREAK, else GNT_DM.
  - if_req with if_flush=1 in IDLE is ignored for that cycle.
- On any grant:
  - Register mem_addr, mem_we (0 for IF) and mem_wdata from the winner; set mem_req=1.
  - These stay frozen until ack. Requester input changes after the grant are ignored.
- dstreak update:
  - DM grant with if_req high: dstreak+1, saturating at MAX_DSTREAK.
  - DM grant with if_req low: dstreak=0.
  - IF grant: dstreak=0.
- GNT_x with mem_ack=1:
  - Same cycle (combinational): x_ready = 1, x_rdata = mem_rdata.
  - At the edge: mem_req=0, next state IDLE.
- Turnaround: exactly one IDLE cycle between transactions. A requester must drop or change its request at the edge where ready=1.
- Latency:
  - Request in IDLE at edge N → mem_req high in cycle N+1.
  - With 1-cycle memory (ack in cycle N+1), ready pulses in cycle N+1.
- if_rdata/dm_rdata when not ready: mem_rdata passes through; the value is don't-care for consumers.
- Flush during GNT_IF:
  - Set drop=1. The transaction still completes on the memory side.
  - On ack, if_ready is suppressed (held 0) and drop is cleared.
  - if_flush coincident with mem_ack also suppresses if_ready.
  - if_flush has no effect in GNT_DM.
- Simultaneous dm_req arrival during GNT_IF: wait; dm_stall=1 until served.
- Reset mid-transaction: mem_req deasserts immediately (async). Any late mem_ack is ignored because the state is IDLE. The memory must tolerate an abandoned request.
- An IF response is never delivered to the DM side and vice versa.

Decomposition:
- Shared package, pipeline-wide: state encoding enum (IDLE/GNT_IF/GNT_DM) and the MAX_DSTREAK default constant.
- Sub-module: arb_streak_ctr (saturating counter with clear/increment/saturated flag). The rest stays flat.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x100; 1-cycle memory returns 0xDEADBEEF.
  - Response: mem_req=1 with mem_addr=0x100, mem_we=0 the cycle after; if_ready=1 with if_rdata=0xDEADBEEF the same cycle as mem_ack; next cycle mem_req=0.
- Store priority:
  - Stimulus: if_req and dm_req (dm_we=1, addr 0x200, wdata 0x55) both raised in IDLE.
  - Response: DM granted first (mem_we=1, mem_wdata=0x55); IF granted after one IDLE cycle.
- Starvation bound:
  - Stimulus: MAX_DSTREAK=4; dm_req re-asserted every turnaround while if_req is held high.
  - Response: exactly 4 DM grants, then an IF grant; dstreak reads 0 afterwards.
- Flush in flight:
  - Stimulus: fetch to 0x300 granted; memory delays ack 3 cycles; if_flush pulsed in cycle 1.
  - Response: mem_ack observed, if_ready stays 0, next grant proceeds normally.
- Reset mid-transaction:
  - Stimulus: assert reset while in GNT_DM with mem_req=1.
  - Response: mem_req=0 asynchronously; after release, state is IDLE, dstreak=0, and a stray mem_ack produces no ready.
- Address hold:
  - Stimulus: after a DM grant, change dm_addr from 0x400 to 0x404 before ack (4-cycle latency).
  - Response: mem_addr stays 0x400 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter types: grant state encoding and streak defaults.
// Used by the memory-port arbiter and its streak counter.
package mem_port_arbiter_pkg;

    localparam int MAX_DSTREAK_DEF = 4;
    localparam int STREAK_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_arb_streak_ctr.sv
// Saturating count of consecutive data-side grants won over a waiting fetch.
// Clear has priority over increment; sat flags the fairness limit.
module arb_streak_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = MAX_DSTREAK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    logic [STREAK_W-1:0] count;

    assign sat = (count == STREAK_W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Registered request port, per-stage stalls, bounded data priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    logic       drop_q, drop_d;
    logic       cnt_clr, cnt_inc, sat;
    logic       if_ok, pick_if, pick_dm;

    arb_streak_ctr #(.MAX(MAX_DSTREAK)) u_streak (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .sat   (sat)
    );

    // A fetch being redirected this cycle does not compete
    assign if_ok   = if_req & ~if_flush;
    assign pick_if = if_ok & (~dm_req | sat);
    assign pick_dm = dm_req & ~pick_if;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick_dm: begin
                        state_d = GNT_DM;
                        cnt_inc = if_req;
                        cnt_clr = ~if_req;
                    end
                    pick_if: begin
                        state_d = GNT_IF;
                        cnt_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
            GNT_IF: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (if_flush) begin
                    drop_d  = 1'b1;
                end
            end
            GNT_DM: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            mem_req <= (state_d != IDLE);
            if (state_q == IDLE && pick_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (state_q == IDLE && pick_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    assign if_ready = (state_q == GNT_IF) & mem_ack & ~drop_q & ~if_flush;
    assign dm_ready = (state_q == GNT_DM) & mem_ack;
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAXD = 4;

    logic        clk, reset;
    logic        if_req, if_flush, if_ready, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXD)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: owner 0=none 1=fetch 2=data
    int          owner, streak, waited, lat, next_lat;
    bit          drop, stray_ack, use_fix;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, rdata_fix;
    bit          obs_ifr, obs_dmr;
    int          n_ifr, n_dmr;

    task automatic model_clear();
        owner = 0; streak = 0; waited = 0; lat = 1; drop = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic tick();
        bit ack, e_ifr, e_dmr, if_ok;
        ack = (owner != 0) && (waited == lat - 1);
        mem_ack = ack | stray_ack;
        mem_rdata = use_fix ? rdata_fix : $urandom;
        @(negedge clk);
        e_ifr = (owner == 1) && ack && !drop && !if_flush;
        e_dmr = (owner == 2) && ack;
        chk("mem_req", 32'(mem_req), 32'(owner != 0));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ready", 32'(if_ready), 32'(e_ifr));
        chk("dm_ready", 32'(dm_ready), 32'(e_dmr));
        chk("if_stall", 32'(if_stall), 32'(if_req && !e_ifr));
        chk("dm_stall", 32'(dm_stall), 32'(dm_req && !e_dmr));
        if (e_ifr) chk("if_rdata", if_rdata, mem_rdata);
        if (e_dmr) chk("dm_rdata", dm_rdata, mem_rdata);
        obs_ifr = if_ready;
        obs_dmr = dm_ready;
        n_ifr += int'(if_ready);
        n_dmr += int'(dm_ready);
        @(posedge clk);
        if (owner != 0) begin
            if (ack) begin
                owner = 0;
                drop  = 0;
            end else begin
                waited++;
                if (owner == 1 && if_flush) drop = 1;
            end
        end else begin
            if_ok = if_req && !if_flush;
            if (dm_req && !(if_ok && streak == MAXD)) begin
                owner = 2; m_we = dm_we; m_addr = dm_addr;
                m_wdata = dm_wdata;
                streak = if_req ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
                waited = 0; lat = next_lat;
            end else if (if_ok) begin
                owner = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
                streak = 0; waited = 0; lat = next_lat;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    int c0;
    bit pf;

    initial begin
        idle_inputs();
        mem_ack = 0; mem_rdata = '0; stray_ack = 0; use_fix = 0;
        rdata_fix = '0; next_lat = 1; n_ifr = 0; n_dmr = 0;
        obs_ifr = 0; obs_dmr = 0;
        do_reset();
        tick();

        // single fetch, 1-cycle memory
        use_fix = 1; rdata_fix = 32'hDEADBEEF; next_lat = 1;
        if_req = 1; if_addr = 32'h100;
        tick();
        tick();
        chk("fetch_ready", 32'(obs_ifr), 32'd1);
        if_req = 0; use_fix = 0;
        tick();

        // data wins, fetch follows after one idle cycle
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h55;
        tick();
        tick();
        chk("sp_dm_first", 32'(obs_dmr), 32'd1);
        chk("sp_if_wait", 32'(obs_ifr), 32'd0);
        dm_req = 0;
        tick();
        tick();
        chk("sp_if_next", 32'(obs_ifr), 32'd1);
        if_req = 0;
        tick();

        // starvation bound
        do_reset();
        if_req = 1; if_addr = 32'h500;
        dm_req = 1; dm_we = 0; dm_addr = 32'h800;
        c0 = n_dmr;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (obs_ifr) break;
            if (obs_dmr) dm_addr = dm_addr + 4;
        end
        chk("starve_if_served", 32'(obs_ifr), 32'd1);
        chk("starve_dm_count", 32'(n_dmr - c0), 32'(MAXD));
        if_addr = 32'h600;
        tick();
        tick();
        chk("streak_cleared", 32'(obs_dmr), 32'd1);
        dm_req = 0;
        repeat (3) tick();
        if_req = 0;
        tick();

        // flush while fetch in flight
        next_lat = 3; if_req = 1; if_addr = 32'h300; c0 = n_ifr;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 0;
        tick();
        tick();
        chk("flush_no_ready", 32'(n_ifr - c0), 32'd0);
        next_lat = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h340;
        tick();
        tick();
        chk("flush_next_grant", 32'(obs_dmr), 32'd1);
        dm_req = 0;
        tick();

        // flush coincident with ack
        next_lat = 2; if_req = 1; if_addr = 32'h310;
        tick();
        tick();
        if_flush = 1;
        tick();
        chk("flush_at_ack", 32'(obs_ifr), 32'd0);
        if_flush = 0; if_req = 0;
        tick();

        // address hold through a slow access
        next_lat = 4; dm_req = 1; dm_we = 1;
        dm_addr = 32'h400; dm_wdata = 32'hAA;
        tick();
        dm_addr = 32'h404;
        repeat (4) begin
            tick();
            chk("hold_addr", mem_addr, 32'h400);
        end
        chk("hold_done", 32'(obs_dmr), 32'd1);
        dm_req = 0;
        tick();

        // reset mid-transaction, then a stray ack
        next_lat = 8; dm_req = 1; dm_we = 1; dm_addr = 32'h700;
        tick();
        tick();
        do_reset();
        dm_req = 0;
        stray_ack = 1;
        tick();
        chk("stray_ack_dm", 32'(obs_dmr), 32'd0);
        chk("stray_ack_if", 32'(obs_ifr), 32'd0);
        stray_ack = 0;
        tick();

        // randomized traffic
        idle_inputs();
        obs_ifr = 0; obs_dmr = 0;
        for (int i = 0; i < 3000; i++) begin
            pf = if_flush;
            if_flush = 0;
            if (if_req && (obs_ifr || pf)) begin
                if_req = 0;
            end else if (!if_req) begin
                if ($urandom % 3 == 0) begin
                    if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom % 10 == 0) begin
                if_flush = 1;
            end
            if (dm_req && obs_dmr) begin
                if ($urandom % 2 == 0) dm_req = 0;
                else begin
                    dm_we = 1'($urandom); dm_addr = $urandom;
                    dm_wdata = $urandom;
                end
            end else if (!dm_req && $urandom % 3 == 0) begin
                dm_req = 1; dm_we = 1'($urandom);
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            next_lat = $urandom_range(4, 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
